// File: rtl/ad9231_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : ad9231_cfg_seq
// Brief    : AD9231 register-write sequencer driving a 24-bit SPI master,
//            with readback verify, bounded retry and done-timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ad9231_cfg_seq #(
    parameter int unsigned START_DLY = 1000,
    parameter int unsigned GAP_CYC   = 16,
    parameter int unsigned DONE_TMO  = 4096,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        kick,
    output logic        spi_start,
    output logic [23:0] spi_tdat,
    input  logic        spi_done,
    input  logic [7:0]  spi_rdata,
    output logic        busy,
    output logic        cfg_ok,
    output logic        cfg_err,
    output logic [1:0]  err_idx
);

    localparam int unsigned c_CNT_MAX =
        (START_DLY > DONE_TMO) ? ((START_DLY > GAP_CYC) ? START_DLY : GAP_CYC)
                               : ((DONE_TMO > GAP_CYC) ? DONE_TMO : GAP_CYC);
    localparam int unsigned c_CNT_W = $clog2(c_CNT_MAX + 2);
    localparam int unsigned c_RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [c_CNT_W-1:0] c_DLY_LAST = c_CNT_W'(START_DLY - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TMO      = c_CNT_W'(DONE_TMO);
    localparam logic [c_RTY_W-1:0] c_MAX_RTY  = c_RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_DLY  = 4'd1,
        S_WR   = 4'd2,
        S_WR_W = 4'd3,
        S_GAP1 = 4'd4,
        S_RD   = 4'd5,
        S_RD_W = 4'd6,
        S_CHK  = 4'd7,
        S_GAP2 = 4'd8,
        S_FIN  = 4'd9,
        S_ERR  = 4'd10
    } state_t;

    function automatic logic [23:0] f_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    f_entry = 24'h000503;
            2'd1:    f_entry = 24'h001420;
            default: f_entry = 24'h00FF01;
        endcase
    endfunction

    // The transfer register self-clears, so it cannot be read back.
    function automatic logic f_verify(input logic [1:0] idx);
        f_verify = (idx != 2'd2);
    endfunction

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_idx;
    logic [c_RTY_W-1:0]   r_rty;
    logic                 r_adv;
    logic [7:0]           r_rdata;
    logic [2:0]           r_sync;

    logic                 w_done_rise;
    logic                 w_retry_ok;
    logic [1:0]           w_next_idx;
    logic [23:0]          w_entry;

    // spi_done changes on the master's negedge: two sync flops plus an edge tap.
    assign w_done_rise = r_sync[1] & ~r_sync[2];
    assign w_retry_ok  = (r_rty < c_MAX_RTY);
    assign w_next_idx  = r_adv ? (r_idx + 2'd1) : r_idx;
    assign w_entry     = f_entry(r_idx);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], spi_done};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_rty     <= '0;
            r_adv     <= 1'b0;
            r_rdata   <= 8'h00;
            spi_start <= 1'b0;
            spi_tdat  <= 24'hFFFFFF;
            busy      <= 1'b0;
            cfg_ok    <= 1'b0;
            cfg_err   <= 1'b0;
            err_idx   <= 2'd0;
        end else begin
            spi_start <= 1'b0;
            case (r_state)
                S_IDLE, S_FIN, S_ERR: begin
                    if (kick) begin
                        cfg_ok  <= 1'b0;
                        cfg_err <= 1'b0;
                        err_idx <= 2'd0;
                        busy    <= 1'b1;
                        r_idx   <= 2'd0;
                        r_rty   <= '0;
                        r_adv   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_DLY;
                    end
                end
                S_DLY: begin
                    if (r_cnt == c_DLY_LAST) begin
                        spi_tdat  <= w_entry;
                        spi_start <= 1'b1;
                        r_cnt     <= c_CNT_W'(1);
                        r_state   <= S_WR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR, S_RD: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_state == S_WR) ? S_WR_W : S_RD_W;
                end
                S_WR_W, S_RD_W: begin
                    // Timeout wins over a done edge landing in the same cycle.
                    if (r_cnt == c_TMO) begin
                        if (w_retry_ok) begin
                            r_rty   <= r_rty + 1'b1;
                            r_adv   <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_GAP2;
                        end else begin
                            cfg_err <= 1'b1;
                            err_idx <= r_idx;
                            busy    <= 1'b0;
                            r_state <= S_ERR;
                        end
                    end else if (w_done_rise) begin
                        r_cnt <= '0;
                        if (r_state == S_RD_W) begin
                            r_rdata <= spi_rdata;
                            r_state <= S_CHK;
                        end else if (f_verify(r_idx)) begin
                            r_state <= S_GAP1;
                        end else begin
                            r_adv   <= 1'b1;
                            r_state <= S_GAP2;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP1: begin
                    if (r_cnt == c_GAP_LAST) begin
                        spi_tdat  <= {8'h80, w_entry[15:8], 8'h00};
                        spi_start <= 1'b1;
                        r_cnt     <= c_CNT_W'(1);
                        r_state   <= S_RD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHK: begin
                    r_cnt <= '0;
                    if (r_rdata == w_entry[7:0]) begin
                        r_adv   <= 1'b1;
                        r_state <= S_GAP2;
                    end else if (w_retry_ok) begin
                        r_rty   <= r_rty + 1'b1;
                        r_adv   <= 1'b0;
                        r_state <= S_GAP2;
                    end else begin
                        cfg_err <= 1'b1;
                        err_idx <= r_idx;
                        busy    <= 1'b0;
                        r_state <= S_ERR;
                    end
                end
                S_GAP2: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_adv <= 1'b0;
                        if (r_adv && (r_idx == 2'd2)) begin
                            cfg_ok  <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_FIN;
                        end else begin
                            if (r_adv) begin
                                r_rty <= '0;
                            end
                            r_idx     <= w_next_idx;
                            spi_tdat  <= f_entry(w_next_idx);
                            spi_start <= 1'b1;
                            r_cnt     <= c_CNT_W'(1);
                            r_state   <= S_WR;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
